bcd4_counter_seg: RTL and testbench

//  Four-digit decimal (BCD) event counter, 0000-9999, with per-digit 7-segment encoding.

---
 rtl/bcd4_counter_seg.sv | 152 +++++++++++++++
 tb/tb_bcd4_counter_seg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd4_counter_seg.sv
// Four-digit BCD event counter (0000-9999) with a clock prescaler and registered
// active-low 7-segment patterns per digit. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd4_counter_seg #(
    parameter int DIV  = 1,
    parameter int DIVW = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        carry,
    output logic [7:0]  LED3,
    output logic [7:0]  LED2,
    output logic [7:0]  LED1,
    output logic [7:0]  LED0
);

    localparam logic [DIVW-1:0] PCNT_LAST = DIVW'(DIV - 1);
    localparam logic [7:0]      SEG_BLANK = 8'hFF;
    localparam logic [7:0]      SEG_ZERO  = 8'h03;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] LED_RESET = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
`else
    localparam logic [31:0] LED_RESET = {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO};
`endif

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off. Non-BCD codes show blank.
    function automatic logic [7:0] seg7_encode(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Packs all four patterns {LED3,LED2,LED1,LED0}; the ones digit is never blanked.
    function automatic logic [31:0] encode_all(input logic [15:0] d);
        logic [31:0] leds;
        leds = {seg7_encode(d[15:12]), seg7_encode(d[11:8]),
                seg7_encode(d[7:4]),   seg7_encode(d[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
        if (d[15:12] == 4'd0) begin
            leds[31:24] = SEG_BLANK;
        end else begin
            leds[31:24] = leds[31:24];
        end
        if (d[15:8] == 8'd0) begin
            leds[23:16] = SEG_BLANK;
        end else begin
            leds[23:16] = leds[23:16];
        end
        if (d[15:4] == 12'd0) begin
            leds[15:8] = SEG_BLANK;
        end else begin
            leds[15:8] = leds[15:8];
        end
`endif
        return leds;
    endfunction

    logic [DIVW-1:0] pcnt_r;
    logic [DIVW-1:0] pcnt_next_s;
    logic            tick_s;
    logic [15:0]     digits_r;
    logic [15:0]     digits_next_s;
    logic            ripple_s;
    logic            wrap_s;
    logic            carry_r;
    logic [31:0]     led_r;
    logic [31:0]     led_next_s;

    // Prescaler: advances only while enabled, wraps and emits a tick on its last count.
    always_comb begin
        tick_s      = 1'b0;
        pcnt_next_s = pcnt_r;
        if (enable) begin
            if (pcnt_r == PCNT_LAST) begin
                tick_s      = 1'b1;
                pcnt_next_s = '0;
            end else begin
                pcnt_next_s = pcnt_r + DIVW'(1);
            end
        end else begin
            pcnt_next_s = pcnt_r;
        end
    end

    // Decimal ripple: a digit rolls to 0 at 9 and passes the increment upward.
    always_comb begin
        digits_next_s = digits_r;
        ripple_s      = tick_s;
        for (int k = 0; k < 4; k++) begin
            if (ripple_s) begin
                // >= keeps a corrupted digit from ever escaping the 0-9 range
                if (digits_r[4*k +: 4] >= 4'd9) begin
                    digits_next_s[4*k +: 4] = 4'd0;
                end else begin
                    digits_next_s[4*k +: 4] = digits_r[4*k +: 4] + 4'd1;
                    ripple_s                = 1'b0;
                end
            end else begin
                digits_next_s[4*k +: 4] = digits_r[4*k +: 4];
            end
        end
        wrap_s = ripple_s;
    end

    // Segment patterns follow the registered digits, one cycle behind them.
    always_comb begin
        led_next_s = encode_all(digits_r);
    end

    // State registers; reset beats clear, clear beats a same-cycle tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_r   <= '0;
            digits_r <= 16'h0000;
            carry_r  <= 1'b0;
            led_r    <= LED_RESET;
        end else if (clear) begin
            pcnt_r   <= '0;
            digits_r <= 16'h0000;
            carry_r  <= 1'b0;
            led_r    <= led_next_s;
        end else begin
            pcnt_r   <= pcnt_next_s;
            digits_r <= digits_next_s;
            carry_r  <= wrap_s;
            led_r    <= led_next_s;
        end
    end

    assign digits = digits_r;
    assign carry  = carry_r;
    assign LED3   = led_r[31:24];
    assign LED2   = led_r[23:16];
    assign LED1   = led_r[15:8];
    assign LED0   = led_r[7:0];

endmodule

// File: tb/tb_bcd4_counter_seg.sv
// Scoreboard bench for bcd4_counter_seg: a DIV=1 and a DIV=4 instance share stimulus,
// a behavioural model pushes per-cycle expectations and a negedge monitor pops them.
module tb_bcd4_counter_seg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] d1_digits, d4_digits;
    logic        d1_carry, d4_carry;
    logic [7:0]  d1_led3, d1_led2, d1_led1, d1_led0;
    logic [7:0]  d4_led3, d4_led2, d4_led1, d4_led0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] digits;
        logic        carry;
        logic [31:0] leds;
    } exp_t;
    exp_t sb[$];

    int          m_cnt[2];
    int          m_pcnt[2];
    logic        m_carry[2];
    logic [31:0] m_led[2];
    int          m_div[2] = '{1, 4};

    logic [7:0] seg_tab[10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    bcd4_counter_seg #(.DIV(1), .DIVW(16)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .digits(d1_digits), .carry(d1_carry),
        .LED3(d1_led3), .LED2(d1_led2), .LED1(d1_led1), .LED0(d1_led0)
    );

    bcd4_counter_seg #(.DIV(4), .DIVW(16)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .digits(d4_digits), .carry(d4_carry),
        .LED3(d4_led3), .LED2(d4_led2), .LED1(d4_led1), .LED0(d4_led0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [31:0] model_leds(input int n);
        logic [31:0] l;
        l = {seg_tab[n / 1000], seg_tab[(n / 100) % 10], seg_tab[(n / 10) % 10], seg_tab[n % 10]};
`ifdef LEADING_ZERO_BLANK_EN
        if (n < 1000) l[31:24] = 8'hFF;
        if (n < 100)  l[23:16] = 8'hFF;
        if (n < 10)   l[15:8]  = 8'hFF;
`endif
        return l;
    endfunction

    // Drive one cycle, advance the model, queue expectations for after the edge.
    task automatic step(input logic en, input logic clr, input logic rst);
        exp_t e;
        enable = en;
        clear  = clr;
        reset  = rst;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_pcnt[i] = 0; m_carry[i] = 1'b0;
                m_led[i] = model_leds(0);
            end else begin
                m_led[i] = model_leds(m_cnt[i]);
                if (clr) begin
                    m_cnt[i] = 0; m_pcnt[i] = 0; m_carry[i] = 1'b0;
                end else begin
                    m_carry[i] = 1'b0;
                    if (en) begin
                        if (m_pcnt[i] == m_div[i] - 1) begin
                            m_pcnt[i]  = 0;
                            m_carry[i] = (m_cnt[i] == 9999);
                            m_cnt[i]   = (m_cnt[i] + 1) % 10000;
                        end else begin
                            m_pcnt[i] = m_pcnt[i] + 1;
                        end
                    end
                end
            end
            e.cyc = cyc + 1; e.idx = i; e.digits = to_bcd(m_cnt[i]);
            e.carry = m_carry[i]; e.leds = m_led[i];
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        logic [15:0] ad;
        logic        ac;
        logic [31:0] al;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            ad = (e.idx == 0) ? d1_digits : d4_digits;
            ac = (e.idx == 0) ? d1_carry  : d4_carry;
            al = (e.idx == 0) ? {d1_led3, d1_led2, d1_led1, d1_led0}
                              : {d4_led3, d4_led2, d4_led1, d4_led0};
            n_tests++;
            if ({ad, ac, al} !== {e.digits, e.carry, e.leds}) begin
                n_fail++;
                $display("FAIL sb_dut%0d cyc=%0d: got digits=%h carry=%b led=%h, expected digits=%h carry=%b led=%h",
                         e.idx, cyc, ad, ac, al, e.digits, e.carry, e.leds);
            end
        end
    end

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({d1_digits, d1_carry} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got digits=%h carry=%b, expected 0000/0", d1_digits, d1_carry);
        end
    endtask

    task automatic test_count_ten();
        step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d1_digits !== 16'h0010) begin
            n_fail++;
            $display("FAIL count_ten: got digits=%h, expected 0010", d1_digits);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({d1_led1, d1_led0} !== {8'h9F, 8'h03}) begin
            n_fail++;
            $display("FAIL count_ten_led: got LED1/0=%h/%h, expected 9F/03", d1_led1, d1_led0);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1);
        repeat (9999) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({d1_digits, d1_led3, d1_led2, d1_led1, d1_led0} !== {16'h9999, 32'h09090909}) begin
            n_fail++;
            $display("FAIL at_9999: got digits=%h led=%h%h%h%h, expected 9999/09090909",
                     d1_digits, d1_led3, d1_led2, d1_led1, d1_led0);
        end
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({d1_digits, d1_carry} !== {16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap: got digits=%h carry=%b, expected 0000/1", d1_digits, d1_carry);
        end
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d1_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_pulse: got carry=%b one cycle after wrap, expected 0", d1_carry);
        end
    endtask

    task automatic test_prescaler();
        step(1'b0, 1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d4_digits !== 16'h0002) begin
            n_fail++;
            $display("FAIL div4_eight: got digits=%h, expected 0002", d4_digits);
        end
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d4_digits !== 16'h0002) begin
            n_fail++;
            $display("FAIL div4_hold: got digits=%h on 3rd enabled cycle, expected 0002", d4_digits);
        end
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d4_digits !== 16'h0003) begin
            n_fail++;
            $display("FAIL div4_fourth: got digits=%h, expected 0003", d4_digits);
        end
    endtask

    task automatic test_clear();
        logic [31:0] zero_leds;
`ifdef LEADING_ZERO_BLANK_EN
        zero_leds = 32'hFFFFFF03;
`else
        zero_leds = 32'h03030303;
`endif
        step(1'b0, 1'b0, 1'b1);
        repeat (99) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({d1_digits, d1_carry} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_vs_tick: got digits=%h carry=%b, expected 0000/0", d1_digits, d1_carry);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({d1_led3, d1_led2, d1_led1, d1_led0} !== zero_leds) begin
            n_fail++;
            $display("FAIL clear_led: got led=%h%h%h%h, expected %h",
                     d1_led3, d1_led2, d1_led1, d1_led0, zero_leds);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] rst_leds;
`ifdef LEADING_ZERO_BLANK_EN
        rst_leds = 32'hFFFFFF03;
`else
        rst_leds = 32'h03030303;
`endif
        step(1'b0, 1'b0, 1'b1);
        repeat (1234) step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (d1_digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL reach_1234: got digits=%h, expected 1234", d1_digits);
        end
        step(1'b1, 1'b0, 1'b1);
        n_tests++;
        if ({d1_digits, d1_carry, d1_led3, d1_led2, d1_led1, d1_led0} !== {16'h0000, 1'b0, rst_leds}) begin
            n_fail++;
            $display("FAIL reset_mid: got digits=%h carry=%b led=%h%h%h%h, expected 0000/0/%h",
                     d1_digits, d1_carry, d1_led3, d1_led2, d1_led1, d1_led0, rst_leds);
        end
`ifdef LEADING_ZERO_BLANK_EN
        repeat (42) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({d1_led3, d1_led2, d1_led1, d1_led0} !== 32'hFFFF9925) begin
            n_fail++;
            $display("FAIL blank_0042: got led=%h%h%h%h, expected FFFF9925",
                     d1_led3, d1_led2, d1_led1, d1_led0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3, 0) != 0), ($urandom_range(49, 0) == 0),
                 ($urandom_range(199, 0) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_count_ten();
        test_wrap();
        test_prescaler();
        test_clear();
        test_reset_mid_count();
        test_back_to_back();
        step(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
